// File: rtl/clb_bitstream_loader.sv
// rtl/clb_bitstream_loader.sv - serialises configuration words LSB-first into a CLB shift-register chain
// Loads exactly NUM_CLB*CLB_BITS bits, then parks in DONE with prog_done set.
module clb_bitstream_loader #(
  parameter int NUM_CLB  = 4,
  parameter int CLB_BITS = 17,
  parameter int WORD_W   = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              chain_out,
  output logic              prog_in,
  output logic              prog_en,
  output logic              prog_busy,
  output logic              prog_done,
  output logic [WORD_W-1:0] rb_data
);

  localparam int TOTAL_BITS = NUM_CLB * CLB_BITS;
  localparam int REM_W      = $clog2(TOTAL_BITS + 1);
  localparam int CNT_W      = $clog2(WORD_W + 1);

  localparam logic [REM_W-1:0] TOTAL_REM = REM_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              ready_d, in_d, en_d, busy_d, done_d;
  logic [WORD_W-1:0] rb_d;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      wcnt_q    <= '0;
      rem_q     <= '0;
      cfg_ready <= 1'b0;
      prog_in   <= 1'b0;
      prog_en   <= 1'b0;
      prog_busy <= 1'b0;
      prog_done <= 1'b0;
      rb_data   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      wcnt_q    <= wcnt_d;
      rem_q     <= rem_d;
      cfg_ready <= ready_d;
      prog_in   <= in_d;
      prog_en   <= en_d;
      prog_busy <= busy_d;
      prog_done <= done_d;
      rb_data   <= rb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    wcnt_d  = wcnt_q;
    rem_d   = rem_q;
    in_d    = prog_in;
    en_d    = 1'b0;
    done_d  = prog_done;
    // The CLBs shift on every edge where prog_en is high, so chain_out here is the bit leaving now.
    rb_d    = prog_en ? {chain_out, rb_data[WORD_W-1:1]} : rb_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          rem_d   = TOTAL_REM;
          wcnt_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          rem_d   = '0;
        end else if (wcnt_q != '0) begin
          in_d    = shreg_q[0];
          en_d    = 1'b1;
          shreg_d = {1'b0, shreg_q[WORD_W-1:1]};
          wcnt_d  = wcnt_q - CNT_ONE;
          rem_d   = (rem_q != '0) ? rem_q - REM_ONE : rem_q;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cfg_valid && cfg_ready) begin
          // Final word may be partial; its upper bits are never shifted out.
          shreg_d = cfg_data;
          wcnt_d  = (int'(rem_q) < WORD_W) ? CNT_W'(rem_q) : WORD_CNT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD) && (wcnt_d == '0) && (rem_d != '0);
    busy_d  = (state_d == S_LOAD);
  end

endmodule

// File: tb/tb_clb_bitstream_loader.sv
// tb/tb_clb_bitstream_loader.sv - randomized self-checking bench for clb_bitstream_loader
// The CLB chain is modelled as one flat shift register; expectations come from the stream mapping.
module tb_clb_bitstream_loader;

  localparam int NUM_CLB   = 2;
  localparam int CLB_BITS  = 17;
  localparam int WORD_W    = 8;
  localparam int TOTAL     = NUM_CLB * CLB_BITS;
  localparam int NUM_WORDS = (TOTAL + WORD_W - 1) / WORD_W;

  typedef logic [WORD_W-1:0] words_t [NUM_WORDS];

  logic              prog_clk, prog_rst_n, start, abort, cfg_valid, cfg_ready;
  logic              chain_out, prog_in, prog_en, prog_busy, prog_done;
  logic [WORD_W-1:0] cfg_data, rb_data;

  logic [TOTAL-1:0]  chain, preload_val, model;
  logic              preload, mon_clr;
  int                en_cnt, gap_cnt;
  int                n_cmp, n_err, to_cnt;
  logic [1:0]        done_edge, gap_end;
  logic [2:0]        post_start;

  clb_bitstream_loader #(
    .NUM_CLB(NUM_CLB), .CLB_BITS(CLB_BITS), .WORD_W(WORD_W)
  ) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .chain_out(chain_out), .prog_in(prog_in), .prog_en(prog_en),
    .prog_busy(prog_busy), .prog_done(prog_done), .rb_data(rb_data)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  assign chain_out = chain[0];

  always @(posedge prog_clk) begin
    if (preload) chain <= preload_val;
    else if (prog_en) chain <= {prog_in, chain[TOTAL-1:1]};
  end

  always @(posedge prog_clk) begin
    if (mon_clr) begin
      en_cnt  <= 0;
      gap_cnt <= 0;
    end else if (prog_en) begin
      en_cnt <= en_cnt + 1;
    end else if (prog_busy && en_cnt > 0 && en_cnt < TOTAL) begin
      gap_cnt <= gap_cnt + 1;
    end
  end

  function automatic logic [TOTAL-1:0] stream_of(input words_t w);
    logic [TOTAL-1:0] r;
    for (int i = 0; i < TOTAL; i++) r[i] = w[i / WORD_W][i % WORD_W];
    return r;
  endfunction

  task automatic pulse_preload(input logic [TOTAL-1:0] v);
    preload_val = v;
    preload = 1'b1;
    @(negedge prog_clk);
    preload = 1'b0;
    model = v;
  endtask

  task automatic preload_random();
    logic [63:0] r;
    r = {$urandom, $urandom};
    pulse_preload(r[TOTAL-1:0]);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d);
    int t = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 300) to_cnt++;
    @(negedge prog_clk);
  endtask

  task automatic do_load(input words_t w, input int gap_after, input int gap_len,
                         input bit mid_start, input bit with_abort);
    logic prev;
    int   t;
    @(negedge prog_clk);
    start = 1'b1; abort = with_abort; mon_clr = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0; mon_clr = 1'b0;
    post_start = {prog_done, prog_busy, cfg_ready};
    for (int k = 0; k < NUM_WORDS; k++) begin
      send_word(w[k]);
      if (k == gap_after) begin
        cfg_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          cfg_data = WORD_W'($urandom);
          @(negedge prog_clk);
        end
        gap_end = {prog_en, cfg_ready};
      end
      if (mid_start && k == 1) begin
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    prev = 1'b0;
    t = 0;
    while (!prog_done && t < 500) begin
      prev = prog_en;
      @(negedge prog_clk);
      t++;
    end
    if (t >= 500) to_cnt++;
    done_edge = {prev, prog_en};
  endtask

  task automatic test_reset();
    #3 prog_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_ready, prog_in, prog_en, prog_busy, prog_done, rb_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b/%h want all zero",
               {cfg_ready, prog_in, prog_en, prog_busy, prog_done}, rb_data);
    end
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    cfg_valid = 1'b1;
    repeat (3) @(negedge prog_clk);
    cfg_valid = 1'b0;
    n_cmp++;
    if ({cfg_ready, prog_en, prog_busy, prog_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 0000", {cfg_ready, prog_en, prog_busy, prog_done});
    end
  endtask

  task automatic test_basic();
    words_t w;
    logic [TOTAL-1:0] old;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h01;
    for (int k = 3; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
    preload_random();
    old = model;
    do_load(w, -1, 0, 1'b0, 1'b0);
    model = stream_of(w);
    n_cmp++;
    if (to_cnt !== 0) begin n_err++; $display("FAIL basic_timeout: got %0d want 0", to_cnt); end
    n_cmp++;
    if (post_start !== 3'b011) begin n_err++; $display("FAIL basic_post_start: got %b want 011", post_start); end
    n_cmp++;
    if (en_cnt !== TOTAL) begin n_err++; $display("FAIL basic_en_count: got %0d want %0d", en_cnt, TOTAL); end
    n_cmp++;
    if (gap_cnt !== NUM_WORDS - 1) begin
      n_err++; $display("FAIL basic_bubbles: got %0d want %0d", gap_cnt, NUM_WORDS - 1);
    end
    n_cmp++;
    if (done_edge !== 2'b10) begin n_err++; $display("FAIL basic_done_latency: got %b want 10", done_edge); end
    n_cmp++;
    if (chain[CLB_BITS-1:0] !== 17'h13CA5) begin
      n_err++; $display("FAIL basic_clb0: got %h want 13ca5", chain[CLB_BITS-1:0]);
    end
    n_cmp++;
    if (chain !== model) begin n_err++; $display("FAIL basic_chain: got %h want %h", chain, model); end
    n_cmp++;
    if (rb_data !== old[TOTAL-1 -: WORD_W]) begin
      n_err++; $display("FAIL basic_readback: got %h want %h", rb_data, old[TOTAL-1 -: WORD_W]);
    end
    repeat (10) @(negedge prog_clk);
    n_cmp++;
    if ({en_cnt, prog_done, prog_busy, cfg_ready} !== {TOTAL, 3'b100} || chain !== model) begin
      n_err++;
      $display("FAIL basic_after_done: got en=%0d done/busy/ready=%b chain=%h want en=%0d 100 %h",
               en_cnt, {prog_done, prog_busy, cfg_ready}, chain, TOTAL, model);
    end
  endtask

  task automatic test_backpressure();
    words_t w;
    logic [TOTAL-1:0] old;
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h01;
    for (int k = 3; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
    old = model;
    do_load(w, 1, 12, 1'b0, 1'b0);
    model = stream_of(w);
    n_cmp++;
    if (to_cnt !== 0) begin n_err++; $display("FAIL bp_timeout: got %0d want 0", to_cnt); end
    n_cmp++;
    if (gap_end !== 2'b01) begin n_err++; $display("FAIL bp_stall_state: got en/ready %b want 01", gap_end); end
    n_cmp++;
    if (gap_cnt !== NUM_WORDS - 1 + 12 - WORD_W) begin
      n_err++; $display("FAIL bp_bubbles: got %0d want %0d", gap_cnt, NUM_WORDS - 1 + 12 - WORD_W);
    end
    n_cmp++;
    if (en_cnt !== TOTAL) begin n_err++; $display("FAIL bp_en_count: got %0d want %0d", en_cnt, TOTAL); end
    n_cmp++;
    if (chain[CLB_BITS-1:0] !== 17'h13CA5 || chain !== model) begin
      n_err++; $display("FAIL bp_chain: got %h want %h", chain, model);
    end
    n_cmp++;
    if (rb_data !== old[TOTAL-1 -: WORD_W]) begin
      n_err++; $display("FAIL bp_readback: got %h want %h", rb_data, old[TOTAL-1 -: WORD_W]);
    end
  endtask

  task automatic test_preload_zero();
    words_t w;
    for (int k = 0; k < NUM_WORDS; k++) w[k] = '0;
    pulse_preload('1);
    do_load(w, -1, 0, 1'b0, 1'b0);
    model = stream_of(w);
    n_cmp++;
    if (rb_data !== 8'hFF) begin n_err++; $display("FAIL zero_readback: got %h want ff", rb_data); end
    n_cmp++;
    if (chain !== '0 || en_cnt !== TOTAL) begin
      n_err++; $display("FAIL zero_chain: got %h en=%0d want 0 en=%0d", chain, en_cnt, TOTAL);
    end
  endtask

  task automatic test_abort();
    words_t w;
    logic [WORD_W-1:0] w0;
    logic [TOTAL-1:0] m;
    int n = 0;
    int t = 0;
    w0 = WORD_W'($urandom);
    @(negedge prog_clk);
    start = 1'b1; mon_clr = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; mon_clr = 1'b0;
    send_word(w0);
    cfg_valid = 1'b0;
    while (n < 6 && t < 100) begin
      @(negedge prog_clk);
      t++;
      if (prog_en) n++;
    end
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    n_cmp++;
    if (n !== 6) begin n_err++; $display("FAIL abort_shift_wait: got %0d want 6", n); end
    n_cmp++;
    if ({prog_busy, prog_en, cfg_ready, prog_done} !== 4'b0000) begin
      n_err++; $display("FAIL abort_outputs: got %b want 0000", {prog_busy, prog_en, cfg_ready, prog_done});
    end
    m = model;
    for (int i = 0; i < 6; i++) m = {w0[i], m[TOTAL-1:1]};
    repeat (4) @(negedge prog_clk);
    n_cmp++;
    if (en_cnt !== 6 || chain !== m) begin
      n_err++; $display("FAIL abort_partial: got en=%0d chain=%h want en=6 chain=%h", en_cnt, chain, m);
    end
    model = m;
    for (int k = 0; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
    do_load(w, -1, 0, 1'b0, 1'b1);
    n_cmp++;
    if (to_cnt !== 0 || en_cnt !== TOTAL || chain !== stream_of(w)) begin
      n_err++;
      $display("FAIL abort_reload: got to=%0d en=%0d chain=%h want 0 %0d %h",
               to_cnt, en_cnt, chain, TOTAL, stream_of(w));
    end
    n_cmp++;
    if (rb_data !== m[TOTAL-1 -: WORD_W]) begin
      n_err++; $display("FAIL abort_reload_readback: got %h want %h", rb_data, m[TOTAL-1 -: WORD_W]);
    end
    model = stream_of(w);
  endtask

  task automatic test_reload();
    words_t w;
    logic [TOTAL-1:0] old;
    @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    @(negedge prog_clk);
    n_cmp++;
    if ({prog_done, prog_busy} !== 2'b10) begin
      n_err++; $display("FAIL done_abort_ignored: got done/busy %b want 10", {prog_done, prog_busy});
    end
    for (int k = 0; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
    old = model;
    do_load(w, -1, 0, 1'b1, 1'b0);
    model = stream_of(w);
    n_cmp++;
    if (post_start !== 3'b011) begin n_err++; $display("FAIL reload_clears_done: got %b want 011", post_start); end
    n_cmp++;
    if (to_cnt !== 0 || en_cnt !== TOTAL || gap_cnt !== NUM_WORDS - 1) begin
      n_err++;
      $display("FAIL reload_counts: got to=%0d en=%0d gaps=%0d want 0 %0d %0d",
               to_cnt, en_cnt, gap_cnt, TOTAL, NUM_WORDS - 1);
    end
    n_cmp++;
    if (chain !== model || rb_data !== old[TOTAL-1 -: WORD_W] || prog_done !== 1'b1) begin
      n_err++;
      $display("FAIL reload_result: got %h/%h/%b want %h/%h/1",
               chain, rb_data, prog_done, model, old[TOTAL-1 -: WORD_W]);
    end
  endtask

  task automatic test_async_reset();
    words_t w;
    logic [TOTAL-1:0] old;
    logic seen = 1'b0;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    send_word(WORD_W'($urandom));
    repeat (2) @(negedge prog_clk);
    cfg_valid = 1'b0;
    n_cmp++;
    if ({prog_en, prog_busy} !== 2'b11) begin
      n_err++; $display("FAIL arst_pre_shift: got en/busy %b want 11", {prog_en, prog_busy});
    end
    #2 prog_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({prog_en, prog_busy, cfg_ready, prog_done, rb_data} !== '0) begin
      n_err++;
      $display("FAIL arst_immediate: got %b/%h want zero", {prog_en, prog_busy, cfg_ready, prog_done}, rb_data);
    end
    @(negedge prog_clk);
    prog_rst_n = 1'b1;
    mon_clr = 1'b1;
    @(negedge prog_clk);
    mon_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_data  = WORD_W'($urandom);
      @(negedge prog_clk);
      seen = seen | cfg_ready | prog_busy | prog_en;
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (seen !== 1'b0 || en_cnt !== 0) begin
      n_err++; $display("FAIL arst_idle_valid: got seen=%b en=%0d want 0 0", seen, en_cnt);
    end
    preload_random();
    old = model;
    for (int k = 0; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
    do_load(w, -1, 0, 1'b0, 1'b0);
    model = stream_of(w);
    n_cmp++;
    if (to_cnt !== 0 || chain !== model || rb_data !== old[TOTAL-1 -: WORD_W]) begin
      n_err++;
      $display("FAIL arst_reload: got to=%0d %h/%h want 0 %h/%h",
               to_cnt, chain, rb_data, model, old[TOTAL-1 -: WORD_W]);
    end
  endtask

  task automatic test_random();
    words_t w;
    logic [TOTAL-1:0] old;
    int ga, gl, xg;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NUM_WORDS; k++) w[k] = WORD_W'($urandom);
      ga = $urandom_range(0, NUM_WORDS - 2);
      gl = $urandom_range(0, 12);
      xg = (gl > WORD_W) ? gl - WORD_W : 0;
      old = model;
      do_load(w, ga, gl, 1'b0, 1'b0);
      model = stream_of(w);
      n_cmp++;
      if (to_cnt !== 0 || en_cnt !== TOTAL || gap_cnt !== NUM_WORDS - 1 + xg) begin
        n_err++;
        $display("FAIL rand_counts[%0d]: got to=%0d en=%0d gaps=%0d want 0 %0d %0d",
                 it, to_cnt, en_cnt, gap_cnt, TOTAL, NUM_WORDS - 1 + xg);
      end
      n_cmp++;
      if (chain !== model || rb_data !== old[TOTAL-1 -: WORD_W]) begin
        n_err++;
        $display("FAIL rand_data[%0d]: got %h/%h want %h/%h",
                 it, chain, rb_data, model, old[TOTAL-1 -: WORD_W]);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; to_cnt = 0;
    prog_rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    preload = 1'b0; preload_val = '0; mon_clr = 1'b0; model = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_preload_zero();
    test_abort();
    test_reload();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule
